// File: rtl/rrf_alloc_ctrl_pkg.sv
// rrf_alloc_ctrl shared constants and helpers.
// RRF sizing lives here next to the other core-wide widths.
package rrf_alloc_ctrl_pkg;

  localparam int RRF_NUM  = 64;
  localparam int RRF_SEL  = 6;
  localparam int REG_SEL  = 5;
  localparam int DATA_LEN = 32;

  // Sum of two request/commit strobes as a 0..2 count.
  function automatic logic [1:0] cnt2(
    input logic a,
    input logic b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rrf_alloc_ctrl_if.sv
// Dispatch / ROB handshake bundle for the RRF allocator.
// master = dispatch + ROB side, slave = allocator.
interface rrf_alloc_ctrl_if #(
  parameter int SEL = 6
);

  logic           dp_req1_i;
  logic           dp_req2_i;
  logic           stall_dp_i;
  logic           com_en1_i;
  logic           com_en2_i;
  logic           flush_i;
  logic [SEL-1:0] dst_rrftag1_o;
  logic [SEL-1:0] dst_rrftag2_o;
  logic           allocatable_o;
  logic           alloc_fire_o;
  logic           stall_o;
  logic [SEL-1:0] rrfptr_o;
  logic [SEL-1:0] comptr_o;
  logic [SEL:0]   freenum_o;
  logic           nextrrfcyc_o;

  modport master (
    output dp_req1_i,
    output dp_req2_i,
    output stall_dp_i,
    output com_en1_i,
    output com_en2_i,
    output flush_i,
    input  dst_rrftag1_o,
    input  dst_rrftag2_o,
    input  allocatable_o,
    input  alloc_fire_o,
    input  stall_o,
    input  rrfptr_o,
    input  comptr_o,
    input  freenum_o,
    input  nextrrfcyc_o
  );

  modport slave (
    input  dp_req1_i,
    input  dp_req2_i,
    input  stall_dp_i,
    input  com_en1_i,
    input  com_en2_i,
    input  flush_i,
    output dst_rrftag1_o,
    output dst_rrftag2_o,
    output allocatable_o,
    output alloc_fire_o,
    output stall_o,
    output rrfptr_o,
    output comptr_o,
    output freenum_o,
    output nextrrfcyc_o
  );

endinterface

// File: rtl/rrf_alloc_ctrl_ptr_adv.sv
// rrf_ptr_adv: advance a {lap, ptr} pair by 0..2.
// The lap bit flips whenever the pointer wraps past the top.
module rrf_ptr_adv #(
  parameter int SEL = 6
) (
  input  logic           lap_i,
  input  logic [SEL-1:0] ptr_i,
  input  logic [1:0]     inc_i,
  output logic           lap_o,
  output logic [SEL-1:0] ptr_o
);

  logic [SEL:0] sum;

  // Carry out of the pointer bits marks a wrap.
  always_comb begin
    sum   = {1'b0, ptr_i} + {{(SEL-1){1'b0}}, inc_i};
    ptr_o = sum[SEL-1:0];
    lap_o = lap_i ^ sum[SEL];
  end

endmodule

// File: rtl/rrf_alloc_ctrl.sv
// rrf_alloc_ctrl: in-order RRF tag allocator / freer.
// Hands out up to 2 tags per cycle, frees on commit, resets on flush.
module rrf_alloc_ctrl #(
  parameter int RRF_NUM = rrf_alloc_ctrl_pkg::RRF_NUM,
  parameter int RRF_SEL = rrf_alloc_ctrl_pkg::RRF_SEL
) (
  input logic             clk,
  input logic             reset,
  rrf_alloc_ctrl_if.slave bus
);

  import rrf_alloc_ctrl_pkg::*;

  localparam logic [RRF_SEL:0] FULL = (RRF_SEL+1)'(RRF_NUM);

  logic [RRF_SEL-1:0] rrfptr_q;
  logic [RRF_SEL-1:0] rrfptr_d;
  logic [RRF_SEL-1:0] comptr_q;
  logic [RRF_SEL-1:0] comptr_d;
  logic               rrfcyc_q;
  logic               rrfcyc_d;
  logic               comcyc_q;
  logic               comcyc_d;
  logic [RRF_SEL:0]   freenum_q;
  logic [RRF_SEL:0]   freenum_d;

  logic [1:0]         reqnum;
  logic [1:0]         allocnum;
  logic [1:0]         comnum;
  logic               allocatable;
  logic               fire;

  logic [RRF_SEL-1:0] aptr_nx;
  logic [RRF_SEL-1:0] cptr_nx;
  logic               alap_nx;
  logic               clap_nx;

  // Handshake: capacity check uses the registered free count only,
  // so a same-cycle commit never enables a same-cycle allocation.
  always_comb begin
    reqnum      = cnt2(bus.dp_req1_i, bus.dp_req2_i);
    comnum      = cnt2(bus.com_en1_i, bus.com_en2_i);
    allocatable = ({{(RRF_SEL-1){1'b0}}, reqnum} <= freenum_q);
    fire        = bus.dp_req1_i & allocatable
                & ~bus.stall_dp_i & ~bus.flush_i;
    allocnum    = fire ? reqnum : 2'd0;
  end

  rrf_ptr_adv #(
    .SEL   (RRF_SEL)
  ) u_alloc_adv (
    .lap_i (rrfcyc_q),
    .ptr_i (rrfptr_q),
    .inc_i (allocnum),
    .lap_o (alap_nx),
    .ptr_o (aptr_nx)
  );

  rrf_ptr_adv #(
    .SEL   (RRF_SEL)
  ) u_com_adv (
    .lap_i (comcyc_q),
    .ptr_i (comptr_q),
    .inc_i (comnum),
    .lap_o (clap_nx),
    .ptr_o (cptr_nx)
  );

  // Next state: flush rewinds the alloc pointer onto the
  // post-commit pointer and frees everything.
  always_comb begin
    comptr_d = cptr_nx;
    comcyc_d = clap_nx;
    rrfptr_d = aptr_nx;
    rrfcyc_d = alap_nx;
    freenum_d = freenum_q
              - {{(RRF_SEL-1){1'b0}}, allocnum}
              + {{(RRF_SEL-1){1'b0}}, comnum};
    if (bus.flush_i) begin
      rrfptr_d  = cptr_nx;
      rrfcyc_d  = clap_nx;
      freenum_d = FULL;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrfptr_q  <= '0;
      comptr_q  <= '0;
      rrfcyc_q  <= 1'b0;
      comcyc_q  <= 1'b0;
      freenum_q <= FULL;
    end else begin
      rrfptr_q  <= rrfptr_d;
      comptr_q  <= comptr_d;
      rrfcyc_q  <= rrfcyc_d;
      comcyc_q  <= comcyc_d;
      freenum_q <= freenum_d;
    end
  end

  assign bus.dst_rrftag1_o = rrfptr_q;
  assign bus.dst_rrftag2_o = rrfptr_q
                           + {{(RRF_SEL-1){1'b0}}, 1'b1};
  assign bus.allocatable_o = allocatable;
  assign bus.alloc_fire_o  = fire;
  assign bus.stall_o       = bus.dp_req1_i & ~allocatable;
  assign bus.rrfptr_o      = rrfptr_q;
  assign bus.comptr_o      = comptr_q;
  assign bus.freenum_o     = freenum_q;
  assign bus.nextrrfcyc_o  = rrfcyc_q;

  a_com2_needs_com1 : assert property (
    @(posedge clk) disable iff (reset)
    bus.com_en1_i || !bus.com_en2_i
  );

  a_req2_needs_req1 : assert property (
    @(posedge clk) disable iff (reset)
    bus.dp_req1_i || !bus.dp_req2_i
  );

  a_no_overcommit : assert property (
    @(posedge clk) disable iff (reset)
    ({1'b0, freenum_q} + {{RRF_SEL{1'b0}}, comnum})
      <= {1'b0, FULL}
  );

  a_full_means_aligned : assert property (
    @(posedge clk) disable iff (reset)
    (freenum_q == FULL) |->
      (rrfptr_q == comptr_q && rrfcyc_q == comcyc_q)
  );

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Directed bench for rrf_alloc_ctrl: vector table + corner sequences.
// Inputs driven on negedge, outputs sampled off the rising edge.
module tb_rrf_alloc_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  rrf_alloc_ctrl_if #(.SEL(6)) bus ();

  rrf_alloc_ctrl #(
    .RRF_NUM (64),
    .RRF_SEL (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r1, r2, st, c1, c2, fl;
    logic [5:0] t1, t2;
    logic       al, fi, so;
    logic [5:0] rp, cp;
    logic [6:0] fn;
    logic       lap;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic r2,
                       input logic st, input logic c1,
                       input logic c2, input logic fl);
    bus.dp_req1_i  = r1;
    bus.dp_req2_i  = r2;
    bus.stall_dp_i = st;
    bus.com_en1_i  = c1;
    bus.com_en2_i  = c2;
    bus.flush_i    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_state(input string tag,
                           input int rp, input int cp,
                           input int fn, input int lap);
    chk({tag, ".rrfptr"},  32'(bus.rrfptr_o),     32'(rp));
    chk({tag, ".comptr"},  32'(bus.comptr_o),     32'(cp));
    chk({tag, ".freenum"}, 32'(bus.freenum_o),    32'(fn));
    chk({tag, ".lap"},     32'(bus.nextrrfcyc_o), 32'(lap));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1,1,0,0,0,0, 0,1, 1,1,0, 2,0,62,0};
    vecs[1] = '{1,0,1,0,0,0, 2,3, 1,0,0, 2,0,62,0};
    vecs[2] = '{1,0,0,0,0,0, 2,3, 1,1,0, 3,0,61,0};
    vecs[3] = '{0,0,0,1,1,0, 3,4, 1,0,0, 3,2,63,0};
    vecs[4] = '{1,1,0,1,0,0, 3,4, 1,1,0, 5,3,62,0};
    vecs[5] = '{1,0,0,1,1,1, 5,6, 1,0,0, 5,5,64,0};
    vecs[6] = '{0,0,0,0,0,0, 5,6, 1,0,0, 5,5,64,0};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 64, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].r1, vecs[i].r2, vecs[i].st,
            vecs[i].c1, vecs[i].c2, vecs[i].fl);
      #1;
      chk($sformatf("v%0d.tag1", i), 32'(bus.dst_rrftag1_o), 32'(vecs[i].t1));
      chk($sformatf("v%0d.tag2", i), 32'(bus.dst_rrftag2_o), 32'(vecs[i].t2));
      chk($sformatf("v%0d.alloc", i), 32'(bus.allocatable_o), 32'(vecs[i].al));
      chk($sformatf("v%0d.fire", i), 32'(bus.alloc_fire_o), 32'(vecs[i].fi));
      chk($sformatf("v%0d.stall", i), 32'(bus.stall_o), 32'(vecs[i].so));
      tick();
      chk_state($sformatf("v%0d", i), vecs[i].rp, vecs[i].cp,
                vecs[i].fn, vecs[i].lap);
    end

    // Fill: 32 double allocations exhaust the tag space.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      #1;
      chk($sformatf("fill%0d.fire", i), 32'(bus.alloc_fire_o), 32'd1);
      @(negedge clk);
    end
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("full.alloc", 32'(bus.allocatable_o), 32'd0);
    chk("full.stall", 32'(bus.stall_o), 32'd1);
    chk("full.fire", 32'(bus.alloc_fire_o), 32'd0);
    chk_state("full", 0, 0, 0, 1);

    // Full + commit: allocation waits for the registered count.
    drive(1, 0, 0, 1, 0, 0);
    #1;
    chk("fullcom.fire", 32'(bus.alloc_fire_o), 32'd0);
    tick();
    chk_state("fullcom", 0, 1, 1, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("refill.alloc", 32'(bus.allocatable_o), 32'd1);
    chk("refill.fire", 32'(bus.alloc_fire_o), 32'd1);
    chk("refill.tag1", 32'(bus.dst_rrftag1_o), 32'd0);
    tick();
    chk_state("refill", 1, 1, 0, 1);

    // Wrap: two tags straddling 63 -> 0.
    do_reset();
    for (int i = 0; i < 31; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      @(negedge clk);
    end
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 0);
    #1;
    chk_state("pre63", 63, 0, 1, 0);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0);
    #1;
    chk("wrap.tag1", 32'(bus.dst_rrftag1_o), 32'd63);
    chk("wrap.tag2", 32'(bus.dst_rrftag2_o), 32'd0);
    chk("wrap.fire", 32'(bus.alloc_fire_o), 32'd1);
    tick();
    chk_state("wrap", 1, 2, 1, 1);

    // Flush with two same-cycle commits after 10 allocations.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      @(negedge clk);
    end
    drive(1, 0, 0, 1, 1, 1);
    #1;
    chk("flush.fire", 32'(bus.alloc_fire_o), 32'd0);
    tick();
    chk_state("flush", 2, 2, 64, 0);

    // External dispatch stall consumes nothing.
    @(negedge clk);
    drive(1, 1, 1, 0, 0, 0);
    #1;
    chk("stall.fire", 32'(bus.alloc_fire_o), 32'd0);
    chk("stall.tag1", 32'(bus.dst_rrftag1_o), 32'd2);
    tick();
    chk_state("stall", 2, 2, 64, 0);
    @(negedge clk);
    #1;
    chk("stall2.tag1", 32'(bus.dst_rrftag1_o), 32'd2);
    chk("stall2.tag2", 32'(bus.dst_rrftag2_o), 32'd3);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      @(negedge clk);
    end
    #1;
    chk("burst.rrfptr", 32'(bus.rrfptr_o), 32'd6);
    #1;
    reset = 1'b1;
    #1;
    chk_state("areset", 0, 0, 64, 0);
    chk("areset.tag2", 32'(bus.dst_rrftag2_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post.fire", 32'(bus.alloc_fire_o), 32'd1);
    tick();
    chk("post.rrfptr", 32'(bus.rrfptr_o), 32'd2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rrf_alloc_ctrl.md
# rrf_alloc_ctrl

Allocation controller for the rename register file (RRF) tag space. It hands out up to two in-order RRF tags per cycle to dispatch, frees them in order as the ROB commits, and tracks the free count and the wrap (lap) bit. On a flush it discards every speculative allocation. Its tag outputs drive the rename table's set-busy port (`dst_rrftag_setbusy_i`) during dispatch.

## Interface
Parameters:
- `RRF_NUM`, 64: number of RRF entries; must be a power of two.
- `RRF_SEL`, 6: tag width, equal to log2(`RRF_NUM`).

Ports:
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dp_req1_i`  in  1  dispatch slot 1 requests a tag.
- `dp_req2_i`  in  1  dispatch slot 2 requests a tag; valid only when `dp_req1_i` is 1.
- `stall_dp_i`  in  1  external dispatch stall; blocks allocation.
- `com_en1_i`  in  1  ROB commits the entry at `comptr_o`.
- `com_en2_i`  in  1  ROB commits the entry at `comptr_o`+1; valid only when `com_en1_i` is 1.
- `flush_i`  in  1  squash all uncommitted allocations.
- `dst_rrftag1_o`  out  `RRF_SEL`  tag for slot 1; equal to `rrfptr_o`.
- `dst_rrftag2_o`  out  `RRF_SEL`  tag for slot 2; equal to (`rrfptr_o`+1) mod `RRF_NUM`.
- `allocatable_o`  out  1  1 when `freenum_o` >= `dp_req1_i`+`dp_req2_i`.
- `alloc_fire_o`  out  1  `dp_req1_i` & `allocatable_o` & ~`stall_dp_i` & ~`flush_i`.
- `stall_o`  out  1  `dp_req1_i` & ~`allocatable_o`.
- `rrfptr_o`  out  `RRF_SEL`  next tag to allocate.
- `comptr_o`  out  `RRF_SEL`  oldest allocated (uncommitted) tag.
- `freenum_o`  out  `RRF_SEL`+1  count of free entries, range 0..`RRF_NUM`.
- `nextrrfcyc_o`  out  1  lap bit of `rrfptr_o`; toggles on each wrap.

## Operation
- Reset values: `rrfptr_o`=0, `comptr_o`=0, `freenum_o`=`RRF_NUM`, `nextrrfcyc_o`=0, internal commit lap bit = 0.
- Allocation count: a = `alloc_fire_o` ? (`dp_req1_i`+`dp_req2_i`) : 0.
- Commit count: c = `com_en1_i`+`com_en2_i`.
- State update without flush:
  - rrfptr <= rrfptr + a, mod `RRF_NUM`.
  - comptr <= comptr + c, mod `RRF_NUM`.
  - freenum <= freenum − a + c.
- Lap bits: a pointer's lap bit toggles when its advance carries out of `RRF_SEL` bits. Example: pointer 63 advanced by 2 becomes 1, lap toggles.
- `allocatable_o` compares against the registered `freenum_o` only. Same-cycle commits do not enable allocation until the next cycle. This is conservative and intentional.
- Flush (`flush_i`=1):
  - Commits in the same cycle still apply: comptr' = comptr + c.
  - rrfptr <= comptr'; `nextrrfcyc_o` <= commit lap bit after advance.
  - freenum <= `RRF_NUM`.
  - No allocation occurs, because `alloc_fire_o` is forced to 0.
- Full and empty:
  - With `freenum_o`=0, `allocatable_o`=0 for any request; the request is held.
  - With `freenum_o`=`RRF_NUM`, rrfptr equals comptr and the lap bits are equal.
- Illegal inputs, checked by assertions and never produced by the ROB or decoder:
  - c > `RRF_NUM` − `freenum_o` (committing more entries than are allocated).
  - `com_en2_i` without `com_en1_i`.
  - `dp_req2_i` without `dp_req1_i`.

## Timing
- Tag outputs, `allocatable_o`, `alloc_fire_o` and `stall_o` are combinational from registered state and current-cycle requests. Dispatch uses the tags in the same cycle.
- Pointer, free-count and lap updates become visible one cycle after the fire/commit edge.
- A request blocked by `stall_dp_i` consumes nothing; the same tags are presented again next cycle.
- Reset asserted mid-operation returns all state to the reset values immediately (asynchronous). The first allocation is possible in the first cycle after deassertion.
- Simultaneous allocate and commit at freenum=0: allocation is blocked that cycle; freenum becomes c on the next edge.

## Structure
- `RRF_NUM` and `RRF_SEL` come from the shared constants header (`Consts.v`), alongside `REG_SEL` and `DATA_LEN`.
- Sub-module `rrf_ptr_adv`: advances a {lap, ptr} pair by 0..2 with modulo wrap. It is instantiated twice, once for the allocation pointer and once for the commit pointer.
- The top level holds the free counter, the flush mux and the handshake logic.

## Test plan
- Reset, then `dp_req1_i`=`dp_req2_i`=1 for one cycle → tags 0 and 1; next cycle `rrfptr_o`=2, `freenum_o`=62.
- Allocate 2 per cycle for 32 cycles → then `freenum_o`=0, `allocatable_o`=0, `stall_o`=1, `rrfptr_o`=0, `nextrrfcyc_o`=1.
- Full state, then `com_en1_i`=1 plus `dp_req1_i`=1 in the same cycle → no allocation that cycle; next cycle `freenum_o`=1, `comptr_o`=1, allocation fires with tag 0.
- `rrfptr_o`=63 with a two-tag request → tags 63 and 0; `nextrrfcyc_o` toggles; `rrfptr_o`=1.
- 10 allocated, then `flush_i`=1 with `com_en1_i`=`com_en2_i`=1 → `comptr_o`=2, `rrfptr_o`=2, `freenum_o`=64.
- `stall_dp_i`=1 with a request → `alloc_fire_o`=0; pointers unchanged; tags stable next cycle.
- Async reset asserted mid-burst → all outputs return to reset values before the next clock edge.
